div_iterative: RTL



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 36 +++
 rtl/div_iterative.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the iterative signed divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_t : controller state encoding (2-bit binary)
//   iter_bits() : width of the iteration counter, clog2(w+1) so the
//                 counter can hold the value w itself
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic int iter_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one radix-2 restoring division step, purely combinational.
//   r_in  : partial remainder (always < divisor, so WIDTH bits suffice)
//   q_in  : dividend bits still to be consumed / quotient bits produced
//   d     : divisor magnitude, WIDTH+1 bits
//   r_out : next partial remainder
//   q_out : next quotient/dividend register, new quotient bit in bit 0
// Kept separate so a radix-4 variant can chain two instances per cycle.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH:0]   d,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    // {R,Q} << 1: the top dividend bit enters the remainder.
    assign r_sh  = {r_in, q_in[WIDTH-1]};
    // Since r_in < d, r_sh < 2d and the difference stays below d when
    // non-negative, so the top bit of trial is a reliable sign.
    assign trial = r_sh - d;

    always_comb begin
        r_out = r_sh[WIDTH-1:0];
        q_out = {q_in[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_out = trial[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iterative.sv
// div_iterative -- multicycle signed integer divider (radix-2 restoring on
// magnitudes, then sign fixup). One quotient bit per clock.
//   clock           : rising-edge clock
//   reset           : synchronous, active-low
//   ctrl_DIV        : start pulse, operands sampled on this edge
//   data_operandA   : dividend, two's complement
//   data_operandB   : divisor, two's complement
//   data_result     : quotient, truncated toward zero (held until next done)
//   data_remainder  : remainder, sign of dividend (held until next done)
//   data_exception  : divide-by-zero, valid with data_resultRDY
//   data_resultRDY  : one-cycle completion pulse
//   busy            : operation in flight
// Latency: WIDTH+2 cycles normally, 2 cycles for divide by zero.
module div_iterative
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int ITER_BITS = iter_bits(WIDTH);

    div_state_t           state;
    logic [WIDTH-1:0]     q;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]     r;       // partial remainder, bounded by divisor
    logic [WIDTH:0]       d;       // divisor magnitude
    logic [ITER_BITS-1:0] cnt;
    logic                 sign_q;
    logic                 sign_r;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     q_nxt;
    logic [WIDTH-1:0]     r_nxt;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic [WIDTH-1:0]     a_back;

    // Local two's-complement negation; the ALU stays free for the pipeline.
    // |-2^(W-1)| = 2^(W-1) still fits as an unsigned WIDTH-bit value.
    assign a_mag = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r),
        .q_in  (q),
        .d     (d),
        .r_out (r_nxt),
        .q_out (q_nxt)
    );

    // Sign fixup. -2^(W-1)/-1 wraps naturally to 2^(W-1) here.
    assign q_fix  = sign_q ? (~q + WIDTH'(1)) : q;
    assign r_fix  = sign_r ? (~r + WIDTH'(1)) : r;
    // On divide by zero q still holds |A|; reapplying A's sign rebuilds A.
    assign a_back = sign_r ? (~q + WIDTH'(1)) : q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            q              <= '0;
            r              <= '0;
            d              <= '0;
            cnt            <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_DIV) begin
            // A start wins over anything in flight, including a pending
            // FIX/DONE: that result is dropped and the outputs are held.
            q              <= a_mag;
            r              <= '0;
            d              <= {1'b0, b_mag};
            sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r         <= data_operandA[WIDTH-1];
            cnt            <= ITER_BITS'(WIDTH);
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
            state          <= (data_operandB == '0) ? DONE : ITER;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: ;
                ITER: begin
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt - ITER_BITS'(1);
                    if (cnt == ITER_BITS'(1))
                        state <= FIX;
                end
                FIX: begin
                    data_result    <= q_fix;
                    data_remainder <= r_fix;
                    data_exception <= 1'b0;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                DONE: begin
                    data_result    <= '0;
                    data_remainder <= a_back;
                    data_exception <= 1'b1;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
